// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side handshake between the UART receiver and its consumer.
// Master is the receiver; slave is the bus-side wrapper.
interface uart_rx_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic       FRAME_ERR;
    logic       OVERRUN;

    modport master (
        output RX_DATA,
        output RX_VALID,
        output FRAME_ERR,
        output OVERRUN,
        input  RX_READY
    );

    modport slave (
        input  RX_DATA,
        input  RX_VALID,
        input  FRAME_ERR,
        input  OVERRUN,
        output RX_READY
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with centre sampling and a
// one-entry holding register with valid/ready, framing and overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      CLK_IN,
    input  logic      RST_N,
    input  logic      RX,
    uart_rx_if.master bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rxs;
    logic          xfer;
    logic          done;

    assign rxs  = sync2_q;
    assign xfer = valid_q & bus.RX_READY;

    assign bus.RX_DATA   = data_q;
    assign bus.RX_VALID  = valid_q;
    assign bus.FRAME_ERR = ferr_q;
    assign bus.OVERRUN   = ovr_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift and holding registers.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame sequencing, bit sampling and holding-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            if (!valid_q || xfer) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the SoC's 8N1 UART link; the receive-side counterpart of the SoC `TX` pin. It synchronizes the `RX` line, detects and qualifies start bits, and samples each bit at its centre. It delivers bytes through a one-entry holding register with a valid/ready handshake. Framing and overrun errors are flagged so the bus-side peripheral wrapper can expose them to software.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): `CLK_IN` cycles per bit; legal range ≥ 4.
- `CLK_IN` input 1: single system clock, rising edge.
- `RST_N` input 1: reset, asynchronous, active-low.
- `RX` input 1: serial line, idle high, asynchronous to `CLK_IN`.
- `RX_DATA` output 8: received byte; valid while `RX_VALID`=1.
- `RX_VALID` output 1: holding register full.
- `RX_READY` input 1: consumer accepts; a transfer occurs on a cycle with `RX_VALID`=1 and `RX_READY`=1.
- `FRAME_ERR` output 1: one-cycle pulse when the stop bit is sampled low.
- `OVERRUN` output 1: one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- **Synchronizer:** `RX` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rxs`.
- **Constants:** HALF = `CLKS_PER_BIT`/2 (integer division). The bit counter width is clog2(`CLKS_PER_BIT`).
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** `rxs`=0 → START, bit counter cleared.
- **START:** sample at HALF after the first low cycle.
  - `rxs`=1 is a glitch → IDLE with no output.
  - `rxs`=0 → DATA, bit index = 0.
- **DATA:** sample every `CLKS_PER_BIT` cycles. Shift bits into the shift register LSB first. After bit 7 → STOP.
- **STOP:** sample after `CLKS_PER_BIT` cycles.
  - `rxs`=1: byte complete → IDLE.
  - `rxs`=0: `FRAME_ERR` pulses, byte discarded → WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs`=1, then → IDLE. A held-low break therefore produces exactly one `FRAME_ERR`.
- **Holding register on byte complete:**
  - `RX_VALID`=0, or a transfer in the same cycle: load `RX_DATA`, `RX_VALID`=1.
  - `RX_VALID`=1 and no transfer: keep the old byte, pulse `OVERRUN`.
- A transfer with no new byte clears `RX_VALID`. `RX_DATA` holds its last value after being consumed.
- A new start bit is accepted from the cycle after the stop sample, so back-to-back frames with no idle gap are received.

## Timing
- **Reset values:** `RX_DATA`=8'h00, `RX_VALID`=0, `FRAME_ERR`=0, `OVERRUN`=0, state IDLE, synchronizer flops = 1. `RST_N` asserted mid-frame aborts the frame immediately; no partial byte or flag is emitted.
- **T0:** the first cycle with `rxs`=0 in IDLE. This is 2 edges after `RX` falls, due to the synchronizer.
- **Sample points:** T0+HALF for the start bit; T0+HALF+k·`CLKS_PER_BIT` for k=1..8 (data bits d0..d7) and k=9 (stop bit).
- **Byte output:** `RX_VALID` and `RX_DATA` update at the edge following the stop sample.
- **Error flags:** `FRAME_ERR` and `OVERRUN` are high for exactly that one cycle.
- **Handshake:** `RX_VALID` deasserts on the edge after a transfer cycle, unless a byte completes in that same cycle. There is no combinational path from `RX_READY` to `RX_VALID`.
- **Tolerance:** reception tolerates ±4% baud mismatch when `CLKS_PER_BIT` ≥ 16.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and drive `RX` with a bench bit-bang task.
- **Single byte:** send 0xA5 with `RX_READY`=0 → `RX_VALID`=1 and `RX_DATA`=0xA5 at T0+8+144+1. Assert `RX_READY` for 1 cycle → `RX_VALID`=0; no error pulses.
- **Glitch:** drive `RX` low for 4 cycles, then high → no `RX_VALID`, state IDLE. A following frame with 0x3C → `RX_DATA`=0x3C.
- **Framing error:** send 0x5A with stop bit 0, hold low 40 cycles, then high → one `FRAME_ERR` pulse, `RX_VALID` stays 0. A next frame with 0xC3 is received correctly.
- **Overrun and back-to-back:**
  - Send 0x11 then 0x22 with no gap and `RX_READY`=0 → `RX_DATA`=0x11, one `OVERRUN` pulse at the 0x22 stop sample; `RX_DATA` stays 0x11.
  - Repeat with `RX_READY`=1 → two one-cycle `RX_VALID` pulses carrying 0x11 then 0x22.
- **Accept and complete in the same cycle:** `RX_VALID`=1 holding 0x11, with `RX_READY` pulsed exactly on the 0x77 completion edge → `RX_VALID` stays 1, `RX_DATA`=0x77, no `OVERRUN`.
- **Reset mid-frame:** assert `RST_N`=0 during data bit 3 of 0xFF, release, then send 0x81 → no output from the aborted frame; `RX_DATA`=0x81, all outputs at reset values while reset is asserted.
